demux_1to4_buf: RTL
===================

Name: demux_1to4_buf

Overview:
- Write-side counterpart of Mux_4to1: steers one `size`-bit input stream to one of four output lanes selected by `sel_i`.
- Each lane has a 1-entry holding register with a valid/ready handshake, so a stalled lane never blocks the other three.
- Used in the simple-MIPS datapath wherever one producer feeds four consumers, e.g. result fan-out to stage buffers.
- Also counts accepted transfers for debug and bench checking.

Parameters:
- size, 32, data width of input and of each output lane (bits).
- CNT_W, 8, width of the accepted-transfer counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- data_i  input  size  input data word.
- sel_i  input  2  destination lane: 0..3 maps to lane 0..3.
- valid_i  input  1  input word present.
- ready_o  output  1  block can accept the input this cycle.
- data0_o..data3_o  output  size each  held data for lanes 0..3.
- valid_o  output  4  bit k: lane k holds a word.
- ready_i  input  4  bit k: consumer k takes lane k's word this cycle.
- cnt_o  output  CNT_W  number of accepted input transfers, modulo 2^CNT_W.

Behaviour:
- Reset (async, rst=1): valid_o=4'b0000, data0_o..data3_o=0, cnt_o=0. Takes effect immediately, not at the next edge. Any held words are discarded.
- ready_o is combinational: ready_o = ~valid_o[sel_i] | ready_i[sel_i]. It depends only on the selected lane and never on valid_i. While rst=1, ready_o is forced to 0.
- Input transfer (accept) = valid_i & ready_o at a rising edge.
- Output transfer on lane k (drain_k) = valid_o[k] & ready_i[k] at a rising edge.
- Latency: an accepted word appears on data{sel_i}_o with valid_o[sel_i]=1 one cycle later. There is no combinational path from data_i to any output.
- Per-lane next state, with fill_k = accept & (sel_i==k):
  - fill_k=1: lane k loads data_i and valid_o[k]=1. This applies whether or not drain_k also occurs; simultaneous drain+fill keeps the lane full with the new word, with no bubble.
  - fill_k=0, drain_k=1: valid_o[k]=0. Data register holds its old value (don't-care to consumers).
  - neither: hold.
- Lanes are independent. Draining any set of lanes in one cycle is legal, together with filling one lane.
- Full lane with ready_i[k]=0 and sel_i=k: ready_o=0 and no accept. The producer must hold data_i/sel_i/valid_i stable until accepted.
- ready_i bits for empty lanes are ignored.
- cnt_o increments by 1 on every accept. It wraps from 2^CNT_W-1 to 0 with no flag.
- sel_i and data_i are don't-care when valid_i=0.
- Reset mid-operation: held words are lost, no drain is signalled, and the counter clears. The first accept after rst falls is counted as 1.

Decomposition:
- Shared constants include (mux_defs.vh): lane select codes LANE0..LANE3 = 2'd0..2'd3. Mux_4to1 uses the same file for its select encoding.
- One sub-module, demux_lane_reg (parameter size), instantiated 4x. Ports: clk, rst, fill, data_in, ready_in, data_out, valid_out.
- The top level holds the sel decode, the ready_o mux, and the counter.

Test Plan:
- Reset: assert rst=1 mid-cycle with lanes full. valid_o=0000, all data=0, cnt_o=0 before the next clk edge, and ready_o=0 while rst=1.
- Fill all lanes (size=15, ready_i=0000): send 39,53,17,26 with sel 0,1,2,3 on consecutive cycles. data0..3_o = 39,53,17,26, valid_o=1111, cnt_o=4.
- Backpressure: with lane 1 full and ready_i[1]=0, present 120 with sel=1. ready_o=0, data1_o stays 53, and cnt_o is unchanged until ready_i[1]=1. Then 120 loads the next cycle and cnt_o=5.
- Simultaneous drain+fill: lane 2 holds 17, ready_i[2]=1, valid_i=1 with sel=2 and data 123. Next cycle data2_o=123, valid_o[2] stays 1, and cnt_o increments.
- Drain only: lane 3 holds 26, ready_i=1000, valid_i=0. Next cycle valid_o=0111 and the other lanes are unchanged.
- Counter wrap (CNT_W=8): 256 accepts to lane 0 with ready_i[0]=1 held. cnt_o returns to 0 and the last word is visible on data0_o.

Source files
------------

// File: rtl/demux_1to4_buf_pkg.sv
// Shared lane-select encoding and decode helper for the 1-to-4 demux / 4-to-1 mux pair.
// Latency: none (constants and a pure function only).
// Backpressure: not applicable.
package demux_1to4_buf_pkg;

    typedef logic [1:0] lane_sel_t;

    localparam lane_sel_t LANE0 = 2'd0;
    localparam lane_sel_t LANE1 = 2'd1;
    localparam lane_sel_t LANE2 = 2'd2;
    localparam lane_sel_t LANE3 = 2'd3;

    localparam int NUM_LANES = 4;

    // One-hot decode of a lane select code; bit k set means lane k is addressed.
    function automatic logic [NUM_LANES-1:0] lane_onehot(input lane_sel_t sel);
        logic [NUM_LANES-1:0] w_hot;
        w_hot = '0;
        case (sel)
            LANE0:   w_hot = 4'b0001;
            LANE1:   w_hot = 4'b0010;
            LANE2:   w_hot = 4'b0100;
            LANE3:   w_hot = 4'b1000;
            default: w_hot = '0;
        endcase
        return w_hot;
    endfunction

endpackage

// File: rtl/demux_1to4_buf_lane_reg.sv
// One output lane: a single-entry holding register with valid/ready handshake.
// Latency: a fill appears on data_out/valid_out one clock later.
// Backpressure: stays full while ready_in=0; fill and drain in the same cycle keep it full.
module demux_lane_reg #(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fill,
    input  logic [size-1:0] data_in,
    input  logic            ready_in,
    output logic [size-1:0] data_out,
    output logic            valid_out
);

    logic [size-1:0] r_data;
    logic            r_valid;

    // Load on fill (wins over drain so there is no bubble); otherwise clear valid when drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (fill) begin
            r_data  <= data_in;
            r_valid <= 1'b1;
        end else if (r_valid && ready_in) begin
            r_valid <= 1'b0;
        end
    end

    assign data_out  = r_data;
    assign valid_out = r_valid;

endmodule

// File: rtl/demux_1to4_buf.sv
// Steers one input stream to one of four buffered output lanes and counts accepted words.
// Latency: one clock from accept to the word being visible on the selected lane.
// Backpressure: ready_o drops only when the selected lane is full and its consumer is not taking it.
module demux_1to4_buf
    import demux_1to4_buf_pkg::*;
#(
    parameter int size  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [size-1:0]  data_i,
    input  logic [1:0]       sel_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [size-1:0]  data0_o,
    output logic [size-1:0]  data1_o,
    output logic [size-1:0]  data2_o,
    output logic [size-1:0]  data3_o,
    output logic [3:0]       valid_o,
    input  logic [3:0]       ready_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [3:0]      w_sel_hot;
    logic [3:0]      w_fill;
    logic [3:0]      w_valid;
    logic [size-1:0] w_data [NUM_LANES];
    logic            w_ready;
    logic            w_accept;
    logic [CNT_W-1:0] r_cnt;

    // Selected lane can take a word if it is empty or being drained this cycle; forced low in reset.
    always_comb begin
        w_ready = 1'b0;
        if (!rst) begin
            w_ready = ~w_valid[sel_i] | ready_i[sel_i];
        end
    end

    assign w_accept  = valid_i & w_ready;
    assign w_sel_hot = lane_onehot(lane_sel_t'(sel_i));
    assign w_fill    = w_sel_hot & {NUM_LANES{w_accept}};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        demux_lane_reg #(
            .size(size)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .fill     (w_fill[g]),
            .data_in  (data_i),
            .ready_in (ready_i[g]),
            .data_out (w_data[g]),
            .valid_out(w_valid[g])
        );
    end

    // Accepted-transfer counter; wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign ready_o = w_ready;
    assign valid_o = w_valid;
    assign data0_o = w_data[0];
    assign data1_o = w_data[1];
    assign data2_o = w_data[2];
    assign data3_o = w_data[3];
    assign cnt_o   = r_cnt;

endmodule
